apb_reg_slave: RTL

APB completer (slave) holding a small bank of read/write registers plus one read-only write-count register. It is the other end of the APB initiator used in the APB test environment: it decodes setup/access phases, inserts programmable wait states via `pready`, flags illegal accesses with `pslverr`, and returns read data that is stable through the access phase. It is the DUT behind the APB bus model in block-level benches.

---
 rtl/apb_reg_slave.sv | 95 +++++++++
 1 files changed

// File: rtl/apb_reg_slave.sv
// rtl/apb_reg_slave.sv - APB completer with R/W register bank, write counter and wait states
`timescale 1ns/1ps
module apb_reg_slave #(
   parameter int AWIDTH      = 4,
   parameter int DWIDTH      = 8,
   parameter int NREGS       = 12,
   parameter int WAIT_STATES = 0
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [AWIDTH-1:0] paddr,
   input  logic [DWIDTH-1:0] pwdata,
   output logic [DWIDTH-1:0] prdata,
   output logic              pready,
   output logic              pslverr
);
   localparam int WW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t            state;
   logic [WW-1:0]     wcnt;
   logic [AWIDTH-1:0] addr_q;
   logic              write_q;
   logic              err_q;
   logic [DWIDTH-1:0] regs [NREGS-1];
   logic [DWIDTH-1:0] wcount;
   logic              setup_err;
   logic [DWIDTH-1:0] setup_rdata;

   // Decode of the address presented in the setup phase; latched only on the setup edge.
   always_comb begin
      setup_err   = (32'(paddr) >= NREGS) || (pwrite && (32'(paddr) == NREGS - 1));
      setup_rdata = '0;
      if (32'(paddr) == NREGS - 1)
         setup_rdata = wcount;
      for (int i = 0; i < NREGS - 1; i++)
         if (32'(paddr) == i)
            setup_rdata = regs[i];
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state   <= IDLE;
         wcnt    <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         wcount  <= '0;
         prdata  <= '0;
         for (int i = 0; i < NREGS - 1; i++)
            regs[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (psel && !penable) begin
                  state   <= ACCESS;
                  wcnt    <= WW'(WAIT_STATES);
                  addr_q  <= paddr;
                  write_q <= pwrite;
                  err_q   <= setup_err;
                  if (!pwrite)
                     prdata <= setup_rdata;
               end
            end
            ACCESS: begin
               if (!psel) begin
                  state <= IDLE;
               end else if (penable) begin
                  if (wcnt != '0) begin
                     wcnt <= wcnt - WW'(1);
                  end else begin
                     state <= IDLE;
                     // err_q already excludes WCNT and unmapped targets, so addr_q is a R/W register here.
                     if (write_q && !err_q) begin
                        for (int i = 0; i < NREGS - 1; i++)
                           if (32'(addr_q) == i)
                              regs[i] <= pwdata;
                        wcount <= wcount + DWIDTH'(1);
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign pready  = (state == ACCESS) && (wcnt == '0);
   assign pslverr = pready && err_q;

endmodule
